// File: rtl/rush3d_pkg.sv
// Definitions shared by the rush3d framebuffer blocks: write-state encodings and
// default framebuffer geometry, also consumed by rush3d_controller.
package rush3d_pkg;

  localparam int FB_WIDTH           = 640;
  localparam int FB_HEIGHT          = 480;
  localparam int FB_WORDS_DEFAULT   = FB_WIDTH * FB_HEIGHT;
  localparam int FB_ADDR_W_DEFAULT  = 19;

  typedef enum logic [3:0] {
    WS_WAIT       = 4'h0,
    WS_WRITE      = 4'h1,
    WS_PURGE      = 4'h2,
    WS_BACKGROUND = 4'h3
  } write_state_e;

endpackage

// File: rtl/rush3d_fill_counter.sv
// Background-fill word address counter; saturates at LAST_ADDR so the final
// write is never followed by a wrap back to zero.
module rush3d_fill_counter #(
  parameter int ADDR_W    = 19,
  parameter int LAST_ADDR = 307199
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance && !last) begin
      count <= count + ADDR_W'(1);
    end
  end

  assign addr = count;
  assign last = (count == ADDR_W'(LAST_ADDR));

endmodule

// File: rtl/rush3d_fb_write_arbiter.sv
// Framebuffer write arbiter: merges rasterizer pixel writes with background
// fills onto one Avalon-style write master, fills taking priority.
//
//   state         | meaning
//   WAIT          | idle; accepts a pixel or starts a pending fill
//   WRITE         | single pixel write held until waitrequest drops
//   BACKGROUND    | sweeping fill colour over every framebuffer word
//   PURGE         | one idle cycle after a fill, pulses fill_done
module rush3d_fb_write_arbiter
  import rush3d_pkg::*;
#(
  parameter int FB_WORDS = FB_WORDS_DEFAULT,
  parameter int ADDR_W   = FB_ADDR_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fill_background_flag,
  input  logic [31:0]       background_colour,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [ADDR_W-1:0] pix_addr,
  input  logic [31:0]       pix_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  input  logic              mem_waitrequest,
  output logic [3:0]        write_state,
  output logic              fill_done,
  output logic              pix_drop
);

  localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W+1)'(FB_WORDS);

  write_state_e      state, state_nxt;
  logic              flag_prev;
  logic              fill_pending;
  logic              run_q;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [31:0]       fill_colour;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_last;
  logic              fill_start;
  logic              fill_advance;
  logic              pix_take;
  logic              flag_rise;
  logic              pix_in_range;

  assign flag_rise    = fill_background_flag && !flag_prev;
  assign pix_in_range = ({1'b0, pix_addr} < FB_LIMIT);
  assign write_state  = state;

  rush3d_fill_counter #(
    .ADDR_W    (ADDR_W),
    .LAST_ADDR (FB_WORDS - 1)
  ) u_fill_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (fill_start),
    .advance (fill_advance),
    .addr    (fill_addr),
    .last    (fill_last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= WS_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // run_q keeps pix_ready low while reset is held and for the release cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flag_prev    <= 1'b0;
      fill_pending <= 1'b0;
      run_q        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      fill_colour  <= '0;
    end else begin
      flag_prev <= fill_background_flag;
      run_q     <= 1'b1;
      // A fresh edge wins over the clear so a re-request is never lost.
      if (flag_rise) begin
        fill_pending <= 1'b1;
      end else if (fill_start) begin
        fill_pending <= 1'b0;
      end
      if (fill_start) begin
        fill_colour <= background_colour;
      end
      if (pix_take) begin
        wr_addr <= pix_addr;
        wr_data <= pix_data;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    pix_ready    = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fill_done    = 1'b0;
    pix_drop     = 1'b0;
    fill_start   = 1'b0;
    fill_advance = 1'b0;
    pix_take     = 1'b0;
    case (state)
      WS_WAIT: begin
        if (fill_pending) begin
          fill_start = 1'b1;
          state_nxt  = WS_BACKGROUND;
        end else if (run_q && !flag_rise) begin
          pix_ready = 1'b1;
          if (pix_valid) begin
            if (pix_in_range) begin
              pix_take  = 1'b1;
              state_nxt = WS_WRITE;
            end else begin
              pix_drop = 1'b1;
            end
          end
        end
      end
      WS_WRITE: begin
        mem_write = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        if (!mem_waitrequest) begin
          state_nxt = WS_WAIT;
        end
      end
      WS_BACKGROUND: begin
        mem_write = 1'b1;
        mem_addr  = fill_addr;
        mem_wdata = fill_colour;
        if (!mem_waitrequest) begin
          fill_advance = 1'b1;
          if (fill_last) begin
            state_nxt = WS_PURGE;
          end
        end
      end
      WS_PURGE: begin
        fill_done = 1'b1;
        state_nxt = WS_WAIT;
      end
      default: begin
        state_nxt = WS_WAIT;
      end
    endcase
  end

endmodule

// File: tb/tb_rush3d_fb_write_arbiter.sv
// Directed bench for rush3d_fb_write_arbiter with a 16-word framebuffer.
module tb_rush3d_fb_write_arbiter;

  localparam int FB_WORDS = 16;
  localparam int ADDR_W   = 19;

  logic              clock;
  logic              reset_n;
  logic              fill_background_flag;
  logic [31:0]       background_colour;
  logic              pix_valid;
  logic              pix_ready;
  logic [ADDR_W-1:0] pix_addr;
  logic [31:0]       pix_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_write;
  logic              mem_waitrequest;
  logic [3:0]        write_state;
  logic              fill_done;
  logic              pix_drop;

  int total = 0;
  int bad   = 0;

  rush3d_fb_write_arbiter #(
    .FB_WORDS (FB_WORDS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .fill_background_flag (fill_background_flag),
    .background_colour    (background_colour),
    .pix_valid            (pix_valid),
    .pix_ready            (pix_ready),
    .pix_addr             (pix_addr),
    .pix_data             (pix_data),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_write            (mem_write),
    .mem_waitrequest      (mem_waitrequest),
    .write_state          (write_state),
    .fill_done            (fill_done),
    .pix_drop             (pix_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Expects to be in BACKGROUND at word 'start'; runs to PURGE and past it.
  // A flag edge is raised while word 'rerise' is being written (-1 = never).
  task automatic fill_body(input logic [31:0] col, input int start, input int rerise);
    for (int i = start; i < FB_WORDS; i++) begin
      if (i == rerise) fill_background_flag = 1'b1;
      else if (i == rerise + 1) fill_background_flag = 1'b0;
      #1;
      chk("fill_state", 32'(write_state), 32'h3);
      chk("fill_write", 32'(mem_write), 32'h1);
      chk("fill_addr", 32'(mem_addr), 32'(i));
      chk("fill_data", mem_wdata, col);
      chk("fill_ready", 32'(pix_ready), 32'h0);
      tick();
    end
    fill_background_flag = 1'b0;
    chk("purge_state", 32'(write_state), 32'h2);
    chk("purge_write", 32'(mem_write), 32'h0);
    chk("purge_done", 32'(fill_done), 32'h1);
    tick();
    chk("post_fill_done", 32'(fill_done), 32'h0);
    chk("post_fill_state", 32'(write_state), 32'h0);
  endtask

  initial begin
    reset_n              = 1'b0;
    fill_background_flag = 1'b0;
    background_colour    = 32'h0;
    pix_valid            = 1'b1;
    pix_addr             = 19'd20;
    pix_data             = 32'h0;
    mem_waitrequest      = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_state", 32'(write_state), 32'h0);
    chk("rst_write", 32'(mem_write), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_ready", 32'(pix_ready), 32'h0);
    chk("rst_drop", 32'(pix_drop), 32'h0);
    chk("rst_done", 32'(fill_done), 32'h0);
    pix_valid = 1'b0;
    reset_n   = 1'b1;
    tick();
    chk("idle_ready", 32'(pix_ready), 32'h1);

    // fill with no stalls
    background_colour    = 32'h00FF00FF;
    fill_background_flag = 1'b1;
    #1;
    chk("rise_ready", 32'(pix_ready), 32'h0);
    tick();
    fill_background_flag = 1'b0;
    chk("pend_state", 32'(write_state), 32'h0);
    chk("pend_ready", 32'(pix_ready), 32'h0);
    chk("pend_write", 32'(mem_write), 32'h0);
    tick();
    background_colour = 32'h12121212;
    fill_body(32'h00FF00FF, 0, -1);
    chk("fill1_ready", 32'(pix_ready), 32'h1);

    // pixel write with three stall cycles
    pix_valid       = 1'b1;
    pix_addr        = 19'd5;
    pix_data        = 32'hDEADBEEF;
    mem_waitrequest = 1'b1;
    #1;
    chk("pix_ready", 32'(pix_ready), 32'h1);
    chk("pix_nowrite", 32'(mem_write), 32'h0);
    tick();
    pix_valid = 1'b0;
    pix_data  = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_waitrequest = 1'b0;
      #1;
      chk("stall_state", 32'(write_state), 32'h1);
      chk("stall_write", 32'(mem_write), 32'h1);
      chk("stall_addr", 32'(mem_addr), 32'h5);
      chk("stall_data", mem_wdata, 32'hDEADBEEF);
      tick();
    end
    chk("stall_end_state", 32'(write_state), 32'h0);
    chk("stall_end_ready", 32'(pix_ready), 32'h1);
    chk("stall_end_write", 32'(mem_write), 32'h0);

    // out-of-range pixel at the first invalid address
    pix_valid = 1'b1;
    pix_addr  = 19'd16;
    #1;
    chk("oor_drop", 32'(pix_drop), 32'h1);
    chk("oor_write", 32'(mem_write), 32'h0);
    tick();
    pix_valid = 1'b0;
    #1;
    chk("oor_state", 32'(write_state), 32'h0);
    chk("oor_write2", 32'(mem_write), 32'h0);
    chk("oor_drop2", 32'(pix_drop), 32'h0);

    // last valid address is accepted
    pix_valid = 1'b1;
    pix_addr  = 19'd15;
    pix_data  = 32'hCAFE0015;
    #1;
    chk("edge_drop", 32'(pix_drop), 32'h0);
    tick();
    pix_valid = 1'b0;
    chk("edge_state", 32'(write_state), 32'h1);
    chk("edge_addr", 32'(mem_addr), 32'hF);
    chk("edge_data", mem_wdata, 32'hCAFE0015);
    tick();
    chk("edge_back", 32'(write_state), 32'h0);

    // collision: fill wins, pixel follows after fill_done
    background_colour    = 32'h0A0B0C0D;
    fill_background_flag = 1'b1;
    pix_valid            = 1'b1;
    pix_addr             = 19'd3;
    pix_data             = 32'h12345678;
    #1;
    chk("col_ready", 32'(pix_ready), 32'h0);
    tick();
    chk("col_pend_ready", 32'(pix_ready), 32'h0);
    tick();
    for (int i = 0; i < FB_WORDS; i++) begin
      chk("col_fill_addr", 32'(mem_addr), 32'(i));
      chk("col_fill_data", mem_wdata, 32'h0A0B0C0D);
      tick();
    end
    chk("col_purge_done", 32'(fill_done), 32'h1);
    tick();
    chk("col_pix_ready", 32'(pix_ready), 32'h1);
    tick();
    pix_valid            = 1'b0;
    fill_background_flag = 1'b0;
    chk("col_pix_state", 32'(write_state), 32'h1);
    chk("col_pix_addr", 32'(mem_addr), 32'h3);
    chk("col_pix_data", mem_wdata, 32'h12345678);
    tick();
    chk("col_end_state", 32'(write_state), 32'h0);

    // reset mid-fill at word 7
    background_colour    = 32'hAAAA5555;
    fill_background_flag = 1'b1;
    tick();
    fill_background_flag = 1'b0;
    tick();
    repeat (7) tick();
    chk("mid_addr", 32'(mem_addr), 32'h7);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(write_state), 32'h0);
    chk("mid_rst_write", 32'(mem_write), 32'h0);
    chk("mid_rst_addr", 32'(mem_addr), 32'h0);
    chk("mid_rst_wdata", mem_wdata, 32'h0);
    chk("mid_rst_ready", 32'(pix_ready), 32'h0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_write", 32'(mem_write), 32'h0);
      chk("post_rst_state", 32'(write_state), 32'h0);
    end
    background_colour    = 32'h5555AAAA;
    fill_background_flag = 1'b1;
    tick();
    fill_background_flag = 1'b0;
    tick();
    // one stall on word 0 must hold the address
    mem_waitrequest = 1'b1;
    #1;
    chk("restart_addr", 32'(mem_addr), 32'h0);
    tick();
    mem_waitrequest = 1'b0;
    chk("stall0_addr", 32'(mem_addr), 32'h0);
    chk("stall0_write", 32'(mem_write), 32'h1);
    tick();
    fill_body(32'h5555AAAA, 1, -1);

    // re-request at word 9 queues exactly one more fill
    background_colour    = 32'h01020304;
    fill_background_flag = 1'b1;
    tick();
    fill_background_flag = 1'b0;
    tick();
    background_colour = 32'h0F0F0F0F;
    fill_body(32'h01020304, 0, 9);
    chk("requeue_ready", 32'(pix_ready), 32'h0);
    tick();
    fill_body(32'h0F0F0F0F, 0, -1);
    chk("final_ready", 32'(pix_ready), 32'h1);
    repeat (3) begin
      tick();
      chk("final_idle_write", 32'(mem_write), 32'h0);
      chk("final_idle_state", 32'(write_state), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
